// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment display source selector.
// Holds the reset pattern, scan-rate presets, channel indices and mode decoding.
package disp_pkg;

  localparam logic [31:0] RST_VAL_DEF    = 32'hAA5555AA;
  localparam int unsigned SCAN_CYC_SIM   = 4;
  localparam int unsigned SCAN_CYC_BOARD = 50_000_000;

  // Channel map of the standard 8-way debug build.
  localparam int unsigned CH_CPU  = 0;
  localparam int unsigned CH_PC   = 1;
  localparam int unsigned CH_CNT  = 2;
  localparam int unsigned CH_INST = 3;
  localparam int unsigned CH_ADDR = 4;
  localparam int unsigned CH_D2B  = 5;
  localparam int unsigned CH_D4B  = 6;
  localparam int unsigned CH_PC2  = 7;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_FREEZE = 2'd2
  } mode_e;

  // Freeze outranks scan, scan outranks manual select.
  function automatic mode_e decode_mode(input logic freeze, input logic scan_en);
    if (freeze)       return MODE_FREEZE;
    else if (scan_en) return MODE_SCAN;
    else              return MODE_MANUAL;
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Dwell timer for auto-scan: counts SCAN_CYC falling edges per channel and
// flags the final cycle so the selector can advance to the next channel.
module disp_scan_timer
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_CYC = SCAN_CYC_BOARD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tick marks the edge on which the counter wraps; hold parks the count.
  assign tick = en && !hold && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (hold)       cnt_d = cnt_q;
    else if (!en)   cnt_d = '0;
    else if (tick)  cnt_d = '0;
    else            cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_src_sel.sv
// Selects the value shown on the seven-segment display: the CPU output register
// or a debug channel, chosen manually, by auto-scan, or held by freeze.
module disp_src_sel
  import disp_pkg::*;
#(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    NCH      = 8,
  parameter int unsigned    SELW     = $clog2(NCH),
  parameter int unsigned    SCAN_CYC = SCAN_CYC_BOARD,
  parameter logic [DW-1:0]  RST_VAL  = DW'(RST_VAL_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_we,
  input  logic [DW-1:0]         cpu_data,
  input  logic [(NCH-1)*DW-1:0] test_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  scan_en,
  input  logic                  freeze,
  output logic [DW-1:0]         disp_num,
  output logic [SELW-1:0]       cur_ch,
  output logic                  scan_tick
);

  localparam int unsigned     NSLOT   = 1 << SELW;
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  logic [DW-1:0]   disp_q, disp_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [DW-1:0]   cpu_hold_q, cpu_hold_d;
  logic            tick_q;
  logic            adv;
  logic            sel_ok;
  mode_e           mode;
  logic [DW-1:0]   ch_val [NSLOT];

  disp_scan_timer #(
    .SCAN_CYC (SCAN_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (scan_en),
    .hold (freeze),
    .tick (adv)
  );

  assign mode   = decode_mode(freeze, scan_en);
  assign sel_ok = ({1'b0, sel} < NCH_W);

  // Channel 0 bypasses a same-edge CPU write so the new value shows at once;
  // unused slots of a non-power-of-two channel count read as zero.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) ch_val[k] = '0;
    ch_val[0] = cpu_we ? cpu_data : cpu_hold_q;
    for (int k = 1; k < NCH; k++) ch_val[k] = test_data[k*DW-1 -: DW];
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    disp_d     = disp_q;
    ch_d       = ch_q;
    cpu_hold_d = cpu_we ? cpu_data : cpu_hold_q;
    case (mode)
      MODE_FREEZE: begin
        disp_d = disp_q;
        ch_d   = ch_q;
      end
      MODE_SCAN: begin
        disp_d = ch_val[ch_q];
        if (adv) ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
      end
      default: begin
        if (sel_ok) begin
          ch_d   = sel;
          disp_d = ch_val[sel];
        end
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      disp_q     <= RST_VAL;
      ch_q       <= '0;
      cpu_hold_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      ch_q       <= ch_d;
      cpu_hold_q <= cpu_hold_d;
      tick_q     <= adv;
    end
  end

  assign disp_num  = disp_q;
  assign cur_ch    = ch_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_disp_src_sel.sv
// Directed bench for disp_src_sel with NCH=8, SCAN_CYC=4; state changes on the
// falling edge, so outputs are sampled just after the following rising edge.
module tb_disp_src_sel;

  localparam int DW   = 32;
  localparam int NCH  = 8;
  localparam int SELW = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cpu_we = 1'b0;
  logic [DW-1:0]         cpu_data = '0;
  logic [(NCH-1)*DW-1:0] test_data = '0;
  logic [SELW-1:0]       sel = '0;
  logic                  scan_en = 1'b0;
  logic                  freeze = 1'b0;
  logic [DW-1:0]         disp_num;
  logic [SELW-1:0]       cur_ch;
  logic                  scan_tick;

  logic [DW-1:0] chv [1:NCH-1];
  int total = 0;
  int bad   = 0;

  disp_src_sel #(
    .DW       (DW),
    .NCH      (NCH),
    .SCAN_CYC (4),
    .RST_VAL  (32'hAA5555AA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_data  (cpu_data),
    .test_data (test_data),
    .sel       (sel),
    .scan_en   (scan_en),
    .freeze    (freeze),
    .disp_num  (disp_num),
    .cur_ch    (cur_ch),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_ch();
    for (int k = 1; k < NCH; k++) test_data[k*DW-1 -: DW] = chv[k];
  endtask

  // One falling edge, then park just after the next rising edge.
  task automatic edge1();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 1; k < NCH; k++) chv[k] = 32'h11111111 * k;
    apply_ch();

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_disp", disp_num, 32'hAA5555AA);
    check("rst_ch", {29'd0, cur_ch}, 32'd0);
    check("rst_tick", {31'd0, scan_tick}, 32'd0);
    #1 rst = 1'b0;

    // Manual select of channel 3.
    chv[3] = 32'hDEADBEEF;
    apply_ch();
    sel = 3'd3;
    edge1();
    check("man_ch3_disp", disp_num, 32'hDEADBEEF);
    check("man_ch3_ch", {29'd0, cur_ch}, 32'd3);

    // CPU channel with same-edge bypass, then hold from cpu_hold.
    sel = 3'd0; cpu_we = 1'b1; cpu_data = 32'h12345678;
    edge1();
    check("cpu_bypass", disp_num, 32'h12345678);
    check("cpu_bypass_ch", {29'd0, cur_ch}, 32'd0);
    cpu_we = 1'b0; cpu_data = 32'hFFFFFFFF;
    edge1();
    check("cpu_hold", disp_num, 32'h12345678);

    // CPU write while another channel is shown lands in cpu_hold.
    sel = 3'd2;
    edge1();
    check("man_ch2", disp_num, 32'h22222222);
    cpu_we = 1'b1; cpu_data = 32'hCAFEF00D;
    edge1();
    check("man_ch2_during_wr", disp_num, 32'h22222222);
    cpu_we = 1'b0; cpu_data = 32'h0; sel = 3'd0;
    edge1();
    check("cpu_hold_bg_write", disp_num, 32'hCAFEF00D);

    // Auto-scan from channel 6: 6,6,6,7(tick),7,7,7,0(tick),0.
    sel = 3'd6;
    edge1();
    check("pre_scan_ch", {29'd0, cur_ch}, 32'd6);
    scan_en = 1'b1; sel = 3'd1;
    for (int i = 1; i <= 9; i++) begin
      edge1();
      check($sformatf("scan_ch_%0d", i), {29'd0, cur_ch},
            (i < 4) ? 32'd6 : (i < 8) ? 32'd7 : 32'd0);
      check($sformatf("scan_tick_%0d", i), {31'd0, scan_tick},
            (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    check("scan_disp_ch0", disp_num, 32'hCAFEF00D);

    // Freeze mid-dwell: counter sits at 1 on channel 0.
    freeze = 1'b1;
    for (int k = 1; k < NCH; k++) chv[k] = 32'hA5000000 + k;
    apply_ch();
    cpu_we = 1'b1; cpu_data = 32'h0BADC0DE;
    for (int i = 1; i <= 10; i++) begin
      edge1();
      check($sformatf("frz_disp_%0d", i), disp_num, 32'hCAFEF00D);
      check($sformatf("frz_ch_%0d", i), {29'd0, cur_ch}, 32'd0);
      check($sformatf("frz_tick_%0d", i), {31'd0, scan_tick}, 32'd0);
    end
    freeze = 1'b0; cpu_we = 1'b0; cpu_data = 32'h0;
    edge1();
    check("unfrz_disp", disp_num, 32'h0BADC0DE);
    check("unfrz_ch_a", {29'd0, cur_ch}, 32'd0);
    edge1();
    check("unfrz_ch_b", {29'd0, cur_ch}, 32'd0);
    edge1();
    check("unfrz_ch_c", {29'd0, cur_ch}, 32'd1);
    check("unfrz_tick_c", {31'd0, scan_tick}, 32'd1);

    // Back to manual on channel 5.
    scan_en = 1'b0; sel = 3'd5;
    edge1();
    check("man_ch5_disp", disp_num, 32'hA5000005);
    check("man_ch5_ch", {29'd0, cur_ch}, 32'd5);

    // Reset in the middle of a scan dwell.
    scan_en = 1'b1;
    edge1();
    edge1();
    check("prerst_ch", {29'd0, cur_ch}, 32'd5);
    rst = 1'b1;
    #1;
    check("midrst_disp", disp_num, 32'hAA5555AA);
    check("midrst_ch", {29'd0, cur_ch}, 32'd0);
    check("midrst_tick", {31'd0, scan_tick}, 32'd0);
    rst = 1'b0;
    edge1();
    check("postrst_disp", disp_num, 32'h00000000);
    check("postrst_ch", {29'd0, cur_ch}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
